branch_cond_unit: RTL and testbench
===================================

Name: branch_cond_unit

Overview:
- Consumes the ALU status flags (negative, zero, overflow, carry_out) and resolves branch decisions for the single-cycle LEGv8 datapath.
- Holds the architectural NZCV flag register, written only by flag-setting instructions (ADDS/SUBS).
- Evaluates B.cond against the held flags, and CBZ/CBNZ against the live ALU zero flag.
- Includes saturating branch/taken counters for debug and performance visibility.

Parameters:
COUNT_W, 32, width of the branch and taken counters.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
alu_negative  input  1  ALU negative flag, current cycle
alu_zero  input  1  ALU zero flag, current cycle
alu_overflow  input  1  ALU overflow flag, current cycle
alu_carry_out  input  1  ALU carry_out flag, current cycle
set_flags  input  1  current instruction writes NZCV (ADDS/SUBS)
br_cond  input  1  current instruction is B.cond
cond  input  4  B.cond condition field, instr[4:0] low 4 bits
cbz  input  1  current instruction is CBZ (ALU in pass-B mode)
cbnz  input  1  current instruction is CBNZ
uncond_br  input  1  current instruction is B or BL
count_clear  input  1  synchronous clear of both counters
branch_taken  output  1  PC-select: take branch target this cycle
flags_q  output  4  held flags {N,Z,C,V}
branch_count  output  COUNT_W  number of branch instructions seen
taken_count  output  COUNT_W  number of taken branches

Behaviour:
- Clock and reset: one clock domain. reset is asynchronous and active-high.
- Reset values: flags_q = 4'b0000, branch_count = 0, taken_count = 0. branch_taken is combinational (0 when no branch input is asserted).
- Flag register:
  - On the clk rising edge with set_flags=1, flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}.
  - Otherwise flags_q holds.
- B.cond evaluation:
  - Uses flags_q as it is before this cycle's edge; there is no same-cycle forwarding.
  - If set_flags and br_cond are both asserted, the branch uses the old flags and the flags still update.
- Condition table (N, Z, C, V taken from flags_q):
  - 0000 EQ Z; 0001 NE !Z
  - 0010 HS C; 0011 LO !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV 1
- branch_taken is combinational, zero latency, and is the OR of:
  - br_cond & cond_true
  - cbz & alu_zero
  - cbnz & !alu_zero
  - uncond_br
- Multiple branch-type inputs asserted together is illegal, but the OR still defines the output. set_flags never affects CBZ/CBNZ.
- Counters, updated at the rising edge:
  - count_clear=1: both counters <= 0. Clear has priority over increment.
  - Otherwise branch_count increments by 1 if any of br_cond/cbz/cbnz/uncond_br is 1.
  - Otherwise taken_count increments by 1 if branch_taken is 1.
  - Each counter saturates at 2^COUNT_W-1; no wrap.
- Reset mid-operation: asserting reset forces flags_q and both counters to 0 immediately, without waiting for clk. Deassertion is synchronized upstream, and the first edge after deassertion behaves normally.
- No X propagation from cond when br_cond=0: cond_true is don't-care but branch_taken must be 0.

Test Plan:
- Reset, then set_flags=1 with ALU flags from FFFF_FFFF_FFFF_FFFF + 1 (N0 Z1 C1 V0), edge -> flags_q=4'b0110. With br_cond=1: cond=0000 taken=1; 0001 taken=0; 0010 taken=1; 1000 taken=0.
- SUBS 5 - 7 flags (N1 Z0 C0 V0) latched -> flags_q=4'b1000. cond=1011 LT taken=1; 1010 GE taken=0; 0011 LO taken=1; 1101 LE taken=1.
- 7FFF_FFFF_FFFF_FFFF + 1 flags (N1 Z0 C0 V1) latched -> flags_q=4'b1001. GE=1, GT=1, VS=1, LT=0. Then drive set_flags=0 with ALU flags 0100 for 3 cycles -> flags_q stays 1001. Then set_flags=1 and br_cond=1 cond=EQ in the same cycle -> taken=0 (old Z=0), and the next cycle flags_q=0100.
- cbz=1 with alu_zero=1 -> taken=1; cbz=1 with alu_zero=0 -> 0; cbnz with the same cases -> 0, 1; uncond_br=1 -> 1; all branch inputs 0 -> 0.
- COUNT_W=4: 20 consecutive taken uncond_br cycles -> branch_count=15, taken_count=15 (saturated). count_clear=1 together with uncond_br=1 -> both counters 0.
- Assert reset asynchronously between clock edges with flags_q=1001 and counters=7 -> all read 0 before the next edge. Release reset, then set_flags=1 -> flags load on the first edge.

Source files
------------

// File: rtl/branch_cond_unit_if.sv
// Bus between the LEGv8 datapath and the branch condition unit: ALU flags and
// decoded branch controls in, PC-select, held NZCV flags and debug counters out.
interface branch_cond_unit_if #(
  parameter int COUNT_W = 32
);
  logic               alu_negative;
  logic               alu_zero;
  logic               alu_overflow;
  logic               alu_carry_out;
  logic               set_flags;
  logic               br_cond;
  logic [3:0]         cond;
  logic               cbz;
  logic               cbnz;
  logic               uncond_br;
  logic               count_clear;
  logic               branch_taken;
  logic [3:0]         flags_q;
  logic [COUNT_W-1:0] branch_count;
  logic [COUNT_W-1:0] taken_count;

  // Datapath/decoder side.
  modport master (
    output alu_negative, alu_zero, alu_overflow, alu_carry_out,
    output set_flags, br_cond, cond, cbz, cbnz, uncond_br, count_clear,
    input  branch_taken, flags_q, branch_count, taken_count
  );

  // Branch condition unit side.
  modport slave (
    input  alu_negative, alu_zero, alu_overflow, alu_carry_out,
    input  set_flags, br_cond, cond, cbz, cbnz, uncond_br, count_clear,
    output branch_taken, flags_q, branch_count, taken_count
  );
endinterface

// File: rtl/branch_cond_unit.sv
// Branch resolution for the single-cycle LEGv8 datapath: held NZCV register,
// B.cond / CBZ / CBNZ / B evaluation and saturating branch/taken counters.
module branch_cond_unit #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  branch_cond_unit_if.slave  bus
);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [3:0]         flags_r;
  logic [COUNT_W-1:0] branch_cnt_r;
  logic [COUNT_W-1:0] taken_cnt_r;
  logic               n_f, z_f, c_f, v_f;
  logic               base_true;
  logic               cond_true;
  logic               any_branch;
  logic               taken;

  assign {n_f, z_f, c_f, v_f} = flags_r;

  // Conditions come in complementary pairs: cond[3:1] picks the base test,
  // cond[0] inverts it, except the 111x pair where both encodings mean always.
  always_comb begin
    base_true = 1'b0;
    case (bus.cond[3:1])
      3'b000:  base_true = z_f;
      3'b001:  base_true = c_f;
      3'b010:  base_true = n_f;
      3'b011:  base_true = v_f;
      3'b100:  base_true = c_f & ~z_f;
      3'b101:  base_true = (n_f == v_f);
      3'b110:  base_true = ~z_f & (n_f == v_f);
      default: base_true = 1'b1;
    endcase
    cond_true = (bus.cond[3:1] == 3'b111) ? 1'b1 : (base_true ^ bus.cond[0]);
  end

  // B.cond sees the flags from before this edge; CBZ/CBNZ use the live ALU zero.
  assign taken = (bus.br_cond & cond_true)
               | (bus.cbz & bus.alu_zero)
               | (bus.cbnz & ~bus.alu_zero)
               | bus.uncond_br;

  assign any_branch = bus.br_cond | bus.cbz | bus.cbnz | bus.uncond_br;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else if (bus.set_flags) begin
      flags_r <= {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_r <= '0;
      taken_cnt_r  <= '0;
    end else if (bus.count_clear) begin
      branch_cnt_r <= '0;
      taken_cnt_r  <= '0;
    end else begin
      if (any_branch && (branch_cnt_r != CNT_MAX)) begin
        branch_cnt_r <= branch_cnt_r + 1'b1;
      end
      if (taken && (taken_cnt_r != CNT_MAX)) begin
        taken_cnt_r <= taken_cnt_r + 1'b1;
      end
    end
  end

  assign bus.branch_taken = taken;
  assign bus.flags_q      = flags_r;
  assign bus.branch_count = branch_cnt_r;
  assign bus.taken_count  = taken_cnt_r;
endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: directed scenarios from the branch rules plus
// randomized cycles, all compared against an ARM-semantics reference model.
module tb_branch_cond_unit;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_cond_unit_if #(.COUNT_W(CW)) bus ();

  branch_cond_unit #(.COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: flags as {N,Z,C,V}, counters as plain integers.
  logic [3:0] m_flags;
  int         m_bc;
  int         m_tc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ARM condition semantics written straight from the mnemonic table.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic model_taken();
    logic t;
    t = 1'b0;
    if (bus.br_cond && model_cond(bus.cond, m_flags)) t = 1'b1;
    if (bus.cbz && bus.alu_zero)                      t = 1'b1;
    if (bus.cbnz && !bus.alu_zero)                    t = 1'b1;
    if (bus.uncond_br)                                t = 1'b1;
    return t;
  endfunction

  // Drive ALU flags as a 64-bit adder would produce them for a + b + cin.
  task automatic drive_add(input logic [63:0] a, input logic [63:0] b, input logic cin);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    bus.alu_negative  = sum[63];
    bus.alu_zero      = (sum[63:0] == 64'd0);
    bus.alu_carry_out = sum[64];
    bus.alu_overflow  = (a[63] == b[63]) && (sum[63] != a[63]);
  endtask

  task automatic idle();
    bus.alu_negative  = 1'b0;
    bus.alu_zero      = 1'b0;
    bus.alu_overflow  = 1'b0;
    bus.alu_carry_out = 1'b0;
    bus.set_flags     = 1'b0;
    bus.br_cond       = 1'b0;
    bus.cond          = 4'h0;
    bus.cbz           = 1'b0;
    bus.cbnz          = 1'b0;
    bus.uncond_br     = 1'b0;
    bus.count_clear   = 1'b0;
  endtask

  // Called 1ns after a rising edge with inputs applied: checks the
  // combinational decision mid-cycle, clocks once, then checks state.
  task automatic step(input string tag, input int exp_t = -1);
    logic t_exp;
    logic any;
    #4;
    t_exp = model_taken();
    any   = bus.br_cond || bus.cbz || bus.cbnz || bus.uncond_br;
    check({tag, "_taken"}, {31'd0, bus.branch_taken}, {31'd0, t_exp});
    if (exp_t >= 0) check({tag, "_plan"}, {31'd0, bus.branch_taken}, exp_t[31:0]);
    @(posedge clk);
    if (bus.set_flags)
      m_flags = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
    if (bus.count_clear) begin
      m_bc = 0;
      m_tc = 0;
    end else begin
      if (any && m_bc < MAXC) m_bc++;
      if (t_exp && m_tc < MAXC) m_tc++;
    end
    #1;
    check({tag, "_flags"}, {28'd0, bus.flags_q}, {28'd0, m_flags});
    check({tag, "_bcnt"}, {28'd0, bus.branch_count}, m_bc[31:0]);
    check({tag, "_tcnt"}, {28'd0, bus.taken_count}, m_tc[31:0]);
  endtask

  task automatic bcond(input logic [3:0] c, input int exp_t);
    idle();
    bus.br_cond = 1'b1;
    bus.cond    = c;
    step("bcond", exp_t);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    m_flags = 4'b0000;
    m_bc    = 0;
    m_tc    = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {28'd0, bus.flags_q}, 32'd0);
    check("rst_bcnt", {28'd0, bus.branch_count}, 32'd0);
    check("rst_tcnt", {28'd0, bus.taken_count}, 32'd0);
    check("rst_taken", {31'd0, bus.branch_taken}, 32'd0);
    reset = 1'b0;

    // 0xFFFF_FFFF_FFFF_FFFF + 1: N0 Z1 C1 V0.
    idle();
    drive_add(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    bus.set_flags = 1'b1;
    step("ld_wrap");
    check("flags_wrap", {28'd0, bus.flags_q}, 32'h6);
    bcond(4'b0000, 1);
    bcond(4'b0001, 0);
    bcond(4'b0010, 1);
    bcond(4'b1000, 0);

    // SUBS 5 - 7 as 5 + ~7 + 1: N1 Z0 C0 V0.
    idle();
    drive_add(64'd5, ~64'd7, 1'b1);
    bus.set_flags = 1'b1;
    step("ld_sub");
    check("flags_sub", {28'd0, bus.flags_q}, 32'h8);
    bcond(4'b1011, 1);
    bcond(4'b1010, 0);
    bcond(4'b0011, 1);
    bcond(4'b1101, 1);

    // 0x7FFF_FFFF_FFFF_FFFF + 1: N1 Z0 C0 V1.
    idle();
    drive_add(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    bus.set_flags = 1'b1;
    step("ld_ovf");
    check("flags_ovf", {28'd0, bus.flags_q}, 32'h9);
    bcond(4'b1010, 1);
    bcond(4'b1100, 1);
    bcond(4'b0110, 1);
    bcond(4'b1011, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.alu_zero = 1'b1;
      step("hold", 0);
      check("flags_hold", {28'd0, bus.flags_q}, 32'h9);
    end
    // Flag write and B.EQ in the same cycle: branch sees the old Z.
    idle();
    bus.alu_zero  = 1'b1;
    bus.set_flags = 1'b1;
    bus.br_cond   = 1'b1;
    bus.cond      = 4'b0000;
    step("same_cyc", 0);
    check("flags_same", {28'd0, bus.flags_q}, 32'h4);

    // CBZ / CBNZ / B, with set_flags asserted to show it has no effect there.
    idle(); bus.cbz = 1'b1;  bus.alu_zero = 1'b1; step("cbz_z", 1);
    idle(); bus.cbz = 1'b1;  bus.alu_zero = 1'b0; bus.set_flags = 1'b1; step("cbz_nz", 0);
    idle(); bus.cbnz = 1'b1; bus.alu_zero = 1'b1; step("cbnz_z", 0);
    idle(); bus.cbnz = 1'b1; bus.alu_zero = 1'b0; step("cbnz_nz", 1);
    idle(); bus.uncond_br = 1'b1; step("uncond", 1);
    idle(); bus.cond = 4'hE; step("none", 0);

    // Saturation of both counters, then clear beating a concurrent increment.
    idle(); bus.count_clear = 1'b1; step("clr0");
    for (int i = 0; i < 20; i++) begin
      idle(); bus.uncond_br = 1'b1; step("sat", 1);
    end
    check("sat_bcnt", {28'd0, bus.branch_count}, 32'd15);
    check("sat_tcnt", {28'd0, bus.taken_count}, 32'd15);
    idle(); bus.count_clear = 1'b1; bus.uncond_br = 1'b1; step("clr_pri", 1);
    check("clr_bcnt", {28'd0, bus.branch_count}, 32'd0);
    check("clr_tcnt", {28'd0, bus.taken_count}, 32'd0);

    // Asynchronous reset mid-cycle with non-zero state.
    idle();
    drive_add(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    bus.set_flags = 1'b1;
    step("ld_pre");
    for (int i = 0; i < 7; i++) begin
      idle(); bus.uncond_br = 1'b1; step("cnt7", 1);
    end
    check("pre_bcnt", {28'd0, bus.branch_count}, 32'd7);
    check("pre_flags", {28'd0, bus.flags_q}, 32'h9);
    idle();
    #2 reset = 1'b1;
    #1;
    check("arst_flags", {28'd0, bus.flags_q}, 32'd0);
    check("arst_bcnt", {28'd0, bus.branch_count}, 32'd0);
    check("arst_tcnt", {28'd0, bus.taken_count}, 32'd0);
    m_flags = 4'b0000;
    m_bc    = 0;
    m_tc    = 0;
    #2 reset = 1'b0;
    drive_add(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    bus.set_flags = 1'b1;
    @(posedge clk);
    m_flags = 4'b1001;
    #1;
    check("post_rst_flags", {28'd0, bus.flags_q}, {28'd0, m_flags});

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int sel;
      idle();
      bus.alu_negative  = 1'($urandom_range(0, 1));
      bus.alu_zero      = 1'($urandom_range(0, 1));
      bus.alu_carry_out = 1'($urandom_range(0, 1));
      bus.alu_overflow  = 1'($urandom_range(0, 1));
      bus.set_flags     = 1'($urandom_range(0, 1));
      bus.cond          = 4'($urandom_range(0, 15));
      bus.count_clear   = ($urandom_range(0, 40) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: ;
        2, 7, 8: bus.br_cond = 1'b1;
        3: bus.cbz = 1'b1;
        4: bus.cbnz = 1'b1;
        5: bus.uncond_br = 1'b1;
        default: begin
          bus.br_cond   = 1'($urandom_range(0, 1));
          bus.cbz       = 1'($urandom_range(0, 1));
          bus.cbnz      = 1'($urandom_range(0, 1));
          bus.uncond_br = 1'($urandom_range(0, 1));
        end
      endcase
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
